// File: rtl/guard_walker_pkg.sv
// guard_walker_pkg: shared types and constants for the guard walker.
//   state_t    - controller states (LOAD, CLEAR, RUN_RD, RUN_EV, DONE)
//   dir_t      - guard heading, numbered clockwise starting at up
//   CH_*       - ASCII characters recognised in the map stream
//   rotate_cw  - next heading after a clockwise quarter turn
package guard_walker_pkg;

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_CLEAR  = 3'd1,
    S_RUN_RD = 3'd2,
    S_RUN_EV = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  localparam logic [7:0] CH_DOT   = 8'h2E;  // '.'
  localparam logic [7:0] CH_HASH  = 8'h23;  // '#'
  localparam logic [7:0] CH_CARET = 8'h5E;  // '^'
  localparam logic [7:0] CH_LF    = 8'h0A;  // '\n'
  localparam logic [7:0] CH_CR    = 8'h0D;  // '\r'

  function automatic dir_t rotate_cw(input dir_t d);
    dir_t r;
    case (d)
      DIR_UP:    r = DIR_RIGHT;
      DIR_RIGHT: r = DIR_DOWN;
      DIR_DOWN:  r = DIR_LEFT;
      DIR_LEFT:  r = DIR_UP;
      default:   r = DIR_UP;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/guard_walker_spram.sv
// guard_walker_spram: synchronous single-port memory, read-first, one-cycle
// read latency. Contents are not reset.
//   clk_i   - clock
//   we_i    - write enable
//   addr_i  - word address
//   wdata_i - write data
//   rdata_o - registered read data (old contents on a write cycle)
module guard_walker_spram #(
  parameter int DW    = 1,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Storage array with registered read port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/guard_walker_step.sv
// guard_step: combinational single-step geometry for the guard.
//   pos_x_i/pos_y_i     - current guard cell
//   dir_i               - current heading
//   width_i/height_i    - grid size in cells
//   ahead_x_o/ahead_y_o - cell in front of the guard (truncated when outside)
//   oob_o               - the cell in front lies outside the grid
//   dir_rot_o           - heading after a clockwise turn
module guard_step import guard_walker_pkg::*; #(
  parameter int COORD_W = 8
) (
  input  logic [COORD_W-1:0] pos_x_i,
  input  logic [COORD_W-1:0] pos_y_i,
  input  dir_t               dir_i,
  input  logic [COORD_W:0]   width_i,
  input  logic [COORD_W:0]   height_i,
  output logic [COORD_W-1:0] ahead_x_o,
  output logic [COORD_W-1:0] ahead_y_o,
  output logic               oob_o,
  output dir_t               dir_rot_o
);

  localparam logic [COORD_W:0] ONE_C = {{COORD_W{1'b0}}, 1'b1};

  logic [COORD_W:0] nx_s;
  logic [COORD_W:0] ny_s;

  // One extra bit lets stepping off the low edge wrap to a huge value, so a
  // single unsigned compare against the grid size catches both edges.
  always_comb begin
    nx_s = {1'b0, pos_x_i};
    ny_s = {1'b0, pos_y_i};
    case (dir_i)
      DIR_UP:    ny_s = {1'b0, pos_y_i} - ONE_C;
      DIR_RIGHT: nx_s = {1'b0, pos_x_i} + ONE_C;
      DIR_DOWN:  ny_s = {1'b0, pos_y_i} + ONE_C;
      DIR_LEFT:  nx_s = {1'b0, pos_x_i} - ONE_C;
      default: begin
        nx_s = {1'b0, pos_x_i};
        ny_s = {1'b0, pos_y_i};
      end
    endcase
  end

  assign ahead_x_o = nx_s[COORD_W-1:0];
  assign ahead_y_o = ny_s[COORD_W-1:0];
  assign oob_o     = (nx_s >= width_i) || (ny_s >= height_i);
  assign dir_rot_o = rotate_cw(dir_i);

endmodule

// File: rtl/guard_walker.sv
// guard_walker: loads an ASCII grid map, then walks a guard that turns
// clockwise at obstacles until it leaves the grid or is caught in a loop,
// reporting the number of distinct cells visited.
//   read_val/_valid/_done - map character stream, end-of-map pulse
//   obs_x/obs_y/obs_en    - extra obstruction, sampled when a walk launches
//   start                 - rerun the walk on the stored map (DONE only)
//   output_data(_valid)   - visited cell count, valid throughout DONE
//   loop_detected         - walk ended in a loop (output_data is then 0)
//   dim_err               - sticky: map exceeded MAX_DIM in either direction
// Build option GUARD_WALKER_LOOP_DIR_EN: store a per-cell heading mask and
// detect loops exactly; otherwise loops are detected by a step limit of
// 4*width*height.
module guard_walker import guard_walker_pkg::*; #(
  parameter int MAX_DIM = 256,
  parameter int CNT_W   = 32,
  parameter int COORD_W = $clog2(MAX_DIM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         read_val,
  input  logic               read_val_valid,
  input  logic               read_val_done,
  input  logic [COORD_W-1:0] obs_x,
  input  logic [COORD_W-1:0] obs_y,
  input  logic               obs_en,
  input  logic               start,
  output logic [CNT_W-1:0]   output_data,
  output logic               output_data_valid,
  output logic               loop_detected,
  output logic               dim_err
);

  localparam int DEPTH = MAX_DIM * MAX_DIM;
  localparam int AW    = $clog2(DEPTH);
  localparam int DIM_W = COORD_W + 1;
  localparam logic [DIM_W-1:0] MAX_DIM_C = DIM_W'(MAX_DIM);
  localparam logic [DIM_W-1:0] ONE_DIM_C = {{COORD_W{1'b0}}, 1'b1};
`ifdef GUARD_WALKER_LOOP_DIR_EN
  localparam int VW = 4;
`else
  localparam int VW = 1;
  localparam int STEP_W = 2 * COORD_W + 4;
`endif

  function automatic logic [AW-1:0] cell_addr(input logic [COORD_W-1:0] cx,
                                               input logic [COORD_W-1:0] cy);
    return AW'(cy) * AW'(MAX_DIM) + AW'(cx);
  endfunction

  state_t               state_q, state_d;
  logic [DIM_W-1:0]     x_q, x_d, rows_q, rows_d;
  logic [DIM_W-1:0]     width_q, width_d, height_q, height_d;
  logic [COORD_W-1:0]   start_x_q, start_x_d, start_y_q, start_y_d;
  logic [COORD_W-1:0]   pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  dir_t                 dir_q, dir_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [COORD_W-1:0]   clr_x_q, clr_x_d, clr_y_q, clr_y_d;
  logic [COORD_W-1:0]   obs_x_q, obs_x_d, obs_y_q, obs_y_d;
  logic                 obs_en_q, obs_en_d;
  logic [CNT_W-1:0]     out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 loop_q, loop_d;
  logic                 dim_err_q, dim_err_d;
`ifndef GUARD_WALKER_LOOP_DIR_EN
  logic [STEP_W-1:0]    steps_q, steps_d, steps_nxt_s, step_prod_s;
`endif

  logic                 map_we_s, map_wdata_s, map_rdata_s;
  logic [AW-1:0]        map_addr_s, vis_addr_s;
  logic                 vis_we_s;
  logic [VW-1:0]        vis_wdata_s, vis_rdata_s, vis_mark_s;
  logic [COORD_W-1:0]   ahead_x_s, ahead_y_s;
  logic                 oob_s, blocked_s, obs_active_s, new_cell_s, loop_hit_s;
  logic                 is_cell_s;
  dir_t                 dir_rot_s;
  logic [CNT_W-1:0]     cnt_inc_s;

  guard_walker_spram #(.DW(1), .DEPTH(DEPTH), .AW(AW)) u_map (
    .clk_i(clk), .we_i(map_we_s), .addr_i(map_addr_s),
    .wdata_i(map_wdata_s), .rdata_o(map_rdata_s)
  );

  guard_walker_spram #(.DW(VW), .DEPTH(DEPTH), .AW(AW)) u_visited (
    .clk_i(clk), .we_i(vis_we_s), .addr_i(vis_addr_s),
    .wdata_i(vis_wdata_s), .rdata_o(vis_rdata_s)
  );

  guard_step #(.COORD_W(COORD_W)) u_step (
    .pos_x_i(pos_x_q), .pos_y_i(pos_y_q), .dir_i(dir_q),
    .width_i(width_q), .height_i(height_q),
    .ahead_x_o(ahead_x_s), .ahead_y_o(ahead_y_s),
    .oob_o(oob_s), .dir_rot_o(dir_rot_s)
  );

  // An obstruction placed on the guard's start cell has no effect.
  assign obs_active_s = obs_en_q && !((obs_x_q == start_x_q) && (obs_y_q == start_y_q));
  assign blocked_s    = map_rdata_s ||
                        (obs_active_s && (ahead_x_s == obs_x_q) && (ahead_y_s == obs_y_q));
  assign is_cell_s    = (read_val == CH_DOT) || (read_val == CH_HASH) || (read_val == CH_CARET);

`ifdef GUARD_WALKER_LOOP_DIR_EN
  assign new_cell_s = (vis_rdata_s == 4'b0000);
  assign loop_hit_s = vis_rdata_s[dir_q];
  assign vis_mark_s = vis_rdata_s | (4'b0001 << dir_q);
`else
  // A non-looping walk visits each (cell, heading) pair at most once, so
  // reaching 4*width*height steps without exiting proves a loop.
  assign new_cell_s  = ~vis_rdata_s[0];
  assign steps_nxt_s = steps_q + STEP_W'(1'b1);
  assign step_prod_s = STEP_W'(width_q) * STEP_W'(height_q);
  assign loop_hit_s  = ~oob_s && (steps_nxt_s >= {step_prod_s[STEP_W-3:0], 2'b00});
  assign vis_mark_s  = 1'b1;
`endif

  assign cnt_inc_s = (new_cell_s && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1'b1) : cnt_q;

  // Next-state, datapath and memory port control.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    rows_d      = rows_q;
    width_d     = width_q;
    height_d    = height_q;
    start_x_d   = start_x_q;
    start_y_d   = start_y_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    dir_d       = dir_q;
    cnt_d       = cnt_q;
    clr_x_d     = clr_x_q;
    clr_y_d     = clr_y_q;
    obs_x_d     = obs_x_q;
    obs_y_d     = obs_y_q;
    obs_en_d    = obs_en_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    loop_d      = loop_q;
    dim_err_d   = dim_err_q;
`ifndef GUARD_WALKER_LOOP_DIR_EN
    steps_d     = steps_q;
`endif
    map_we_s    = 1'b0;
    map_addr_s  = cell_addr(x_q[COORD_W-1:0], rows_q[COORD_W-1:0]);
    map_wdata_s = 1'b0;
    vis_we_s    = 1'b0;
    vis_addr_s  = cell_addr(pos_x_q, pos_y_q);
    vis_wdata_s = {VW{1'b0}};

    case (state_q)
      S_LOAD: begin
        if (read_val_done) begin
          // A final row without a trailing newline still counts.
          if ((x_q != {DIM_W{1'b0}}) && (rows_q < MAX_DIM_C)) begin
            height_d = rows_q + ONE_DIM_C;
            if (rows_q == {DIM_W{1'b0}}) begin
              width_d = x_q;
            end else begin
              width_d = width_q;
            end
          end else begin
            height_d = rows_q;
          end
          // The first walk launches here, so capture the obstruction too.
          obs_x_d  = obs_x;
          obs_y_d  = obs_y;
          obs_en_d = obs_en;
          clr_x_d  = {COORD_W{1'b0}};
          clr_y_d  = {COORD_W{1'b0}};
          state_d  = S_CLEAR;
        end else if (read_val_valid) begin
          if (is_cell_s) begin
            if ((x_q >= MAX_DIM_C) || (rows_q >= MAX_DIM_C)) begin
              dim_err_d = 1'b1;
            end else begin
              map_we_s    = 1'b1;
              map_wdata_s = (read_val == CH_HASH);
              x_d         = x_q + ONE_DIM_C;
              if (read_val == CH_CARET) begin
                start_x_d = x_q[COORD_W-1:0];
                start_y_d = rows_q[COORD_W-1:0];
              end else begin
                start_x_d = start_x_q;
              end
            end
          end else if (read_val == CH_LF) begin
            if (rows_q >= MAX_DIM_C) begin
              dim_err_d = 1'b1;
            end else begin
              if (rows_q == {DIM_W{1'b0}}) begin
                width_d = x_q;
              end else begin
                width_d = width_q;
              end
              rows_d = rows_q + ONE_DIM_C;
              x_d    = {DIM_W{1'b0}};
            end
          end else begin
            x_d = x_q;  // '\r' and any other character are ignored
          end
        end else begin
          x_d = x_q;
        end
      end

      S_CLEAR: begin
        pos_x_d  = start_x_q;
        pos_y_d  = start_y_q;
        dir_d    = DIR_UP;
        cnt_d    = {CNT_W{1'b0}};
`ifndef GUARD_WALKER_LOOP_DIR_EN
        steps_d  = {STEP_W{1'b0}};
`endif
        if ((width_q == {DIM_W{1'b0}}) || (height_q == {DIM_W{1'b0}})) begin
          // Empty grid: nothing to walk.
          out_data_d  = {CNT_W{1'b0}};
          loop_d      = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          vis_we_s   = 1'b1;
          vis_addr_s = cell_addr(clr_x_q, clr_y_q);
          if (DIM_W'(clr_x_q) == (width_q - ONE_DIM_C)) begin
            clr_x_d = {COORD_W{1'b0}};
            if (DIM_W'(clr_y_q) == (height_q - ONE_DIM_C)) begin
              state_d = S_RUN_RD;
            end else begin
              clr_y_d = clr_y_q + {{(COORD_W-1){1'b0}}, 1'b1};
            end
          end else begin
            clr_x_d = clr_x_q + {{(COORD_W-1){1'b0}}, 1'b1};
          end
        end
      end

      S_RUN_RD: begin
        map_addr_s = cell_addr(ahead_x_s, ahead_y_s);
        vis_addr_s = cell_addr(pos_x_q, pos_y_q);
        state_d    = S_RUN_EV;
      end

      S_RUN_EV: begin
        vis_we_s    = 1'b1;
        vis_wdata_s = vis_mark_s;
        cnt_d       = cnt_inc_s;
`ifndef GUARD_WALKER_LOOP_DIR_EN
        steps_d     = steps_nxt_s;
`endif
        if (loop_hit_s) begin
          out_data_d  = {CNT_W{1'b0}};
          loop_d      = 1'b1;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if (oob_s) begin
          out_data_d  = cnt_inc_s;
          loop_d      = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          // A turn consumes a whole step; the exit test sees the new heading
          // on the following evaluation.
          if (blocked_s) begin
            dir_d = dir_rot_s;
          end else begin
            pos_x_d = ahead_x_s;
            pos_y_d = ahead_y_s;
          end
          state_d = S_RUN_RD;
        end
      end

      S_DONE: begin
        if (start) begin
          obs_x_d     = obs_x;
          obs_y_d     = obs_y;
          obs_en_d    = obs_en;
          clr_x_d     = {COORD_W{1'b0}};
          clr_y_d     = {COORD_W{1'b0}};
          out_valid_d = 1'b0;
          state_d     = S_CLEAR;
        end else begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD;
      x_q         <= {DIM_W{1'b0}};
      rows_q      <= {DIM_W{1'b0}};
      width_q     <= {DIM_W{1'b0}};
      height_q    <= {DIM_W{1'b0}};
      start_x_q   <= {COORD_W{1'b0}};
      start_y_q   <= {COORD_W{1'b0}};
      pos_x_q     <= {COORD_W{1'b0}};
      pos_y_q     <= {COORD_W{1'b0}};
      dir_q       <= DIR_UP;
      cnt_q       <= {CNT_W{1'b0}};
      clr_x_q     <= {COORD_W{1'b0}};
      clr_y_q     <= {COORD_W{1'b0}};
      obs_x_q     <= {COORD_W{1'b0}};
      obs_y_q     <= {COORD_W{1'b0}};
      obs_en_q    <= 1'b0;
      out_data_q  <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
      loop_q      <= 1'b0;
      dim_err_q   <= 1'b0;
`ifndef GUARD_WALKER_LOOP_DIR_EN
      steps_q     <= {STEP_W{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      rows_q      <= rows_d;
      width_q     <= width_d;
      height_q    <= height_d;
      start_x_q   <= start_x_d;
      start_y_q   <= start_y_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      clr_x_q     <= clr_x_d;
      clr_y_q     <= clr_y_d;
      obs_x_q     <= obs_x_d;
      obs_y_q     <= obs_y_d;
      obs_en_q    <= obs_en_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      loop_q      <= loop_d;
      dim_err_q   <= dim_err_d;
`ifndef GUARD_WALKER_LOOP_DIR_EN
      steps_q     <= steps_d;
`endif
    end
  end

  assign output_data       = out_data_q;
  assign output_data_valid = out_valid_q;
  assign loop_detected     = loop_q;
  assign dim_err           = dim_err_q;

endmodule

// File: doc/guard_walker.md
GUARD_WALKER -- requirements
Module: guard_walker

Interface
REQ-001 Parameter MAX_DIM, default 256, maximum grid width and height in cells.
REQ-002 Parameter CNT_W, default 32, width of the result counter.
REQ-003 Parameter COORD_W, default $clog2(MAX_DIM), width of coordinates.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 read_val  in  8  ASCII map character.
REQ-007 read_val_valid  in  1  read_val valid this cycle.
REQ-008 read_val_done  in  1  one-cycle pulse: map stream ended.
REQ-009 obs_x, obs_y  in  COORD_W  extra obstruction coordinate, sampled on start.
REQ-010 obs_en  in  1  extra obstruction enabled, sampled on start.
REQ-011 start  in  1  one-cycle pulse: rerun walk on the stored map, legal only in DONE.
REQ-012 output_data  out  CNT_W  distinct visited cell count.
REQ-013 output_data_valid  out  1  result valid; high throughout DONE.
REQ-014 loop_detected  out  1  walk ended in a loop; qualified by output_data_valid.
REQ-015 dim_err  out  1  sticky: row or row count exceeded MAX_DIM.

Function
REQ-016 States SHALL be LOAD, CLEAR, RUN_RD, RUN_EV, DONE; LOAD->CLEAR on read_val_done; CLEAR->RUN_RD after last cell cleared; RUN_EV->RUN_RD per step; RUN_EV->DONE on exit or loop; DONE->CLEAR on start.
REQ-017 LOAD: '.' writes 0, '#' writes 1, '^' writes 0 and records guard start, dir=up; '\n' ends row; '\r' and others ignored; x increments on '.', '#', '^'.
REQ-018 Width SHALL equal the first row's cell count; height SHALL equal rows, counting a final unterminated row with x>0.
REQ-019 Characters at x>=MAX_DIM or rows>=MAX_DIM SHALL be dropped and set dim_err.
REQ-020 CLEAR SHALL zero width*height visited entries, one per cycle, and reset guard to start, dir=up, count=0.
REQ-021 RUN_RD SHALL issue map and visited reads for the current and ahead cells; memory read latency is one cycle.
REQ-022 RUN_EV: if current cell's visited entry is zero, count SHALL increment by 1 (saturating at 2^CNT_W-1).
REQ-023 Ahead cell blocked (map bit 1, or obs_en and ahead==(obs_x,obs_y)) SHALL rotate dir clockwise (up,right,down,left) without moving; else the guard SHALL move one cell.
REQ-024 An obstruction coordinate equal to the guard start SHALL be ignored.
REQ-025 Ahead cell outside 0..width-1 / 0..height-1 SHALL end the walk: current cell counted, output_data=count, loop_detected=0, DONE.
REQ-026 Turning and exit on the same cycle: exit is evaluated after rotation, so a turn is one step and exit is checked on the next RUN_EV.
REQ-027 Each RUN_EV SHALL write the current cell's visited entry.
REQ-028 start outside DONE, and read_val_valid outside LOAD, SHALL be ignored.
REQ-029 output_data_valid SHALL rise on the cycle DONE is entered and fall on start.

Reset
REQ-030 rst SHALL force LOAD, clear width, height, guard, count, dim_err, loop_detected, output_data=0, output_data_valid=0, at any time including mid-walk.
REQ-031 Memory contents are not reset; CLEAR guarantees visited state before every walk.

Configuration
REQ-032 With GUARD_WALKER_LOOP_DIR_EN defined: visited entries are 4-bit direction masks; entering RUN_EV with the current dir bit already set SHALL end with loop_detected=1, output_data=0.
REQ-033 Without it: visited entries are 1 bit; a step counter reaching 4*width*height SHALL end with loop_detected=1, output_data=0.

Structure
REQ-034 guard_walker_pkg SHALL hold state_t, dir_t, ASCII constants '.', '#', '^', '\n', '\r'.
REQ-035 Sub-module guard_step SHALL compute ahead coordinate, out-of-bounds flag and rotated dir combinationally.
REQ-036 Map and visited storage SHALL be the codebase's synchronous single-port memory, depth MAX_DIM*MAX_DIM, address y*MAX_DIM+x.

Verification
REQ-037 Standard 10x10 puzzle example, obs_en=0 -> output_data=41, loop_detected=0.
REQ-038 Same map, start with obs (3,6) -> output_data_valid=1, loop_detected=1, output_data=0.
REQ-039 Then start with obs_en=0 -> 41 again, map not reloaded.
REQ-040 ".^.\n" -> output_data=1 after one RUN_EV; "#\n^\n" -> one turn then exit, output_data=1.
REQ-041 rst pulse mid-RUN -> output_data=0, output_data_valid=0, state LOAD; reload gives correct result.
REQ-042 Row of MAX_DIM+1 '.' characters -> dim_err=1, width=MAX_DIM.
